mem_load_store_unit: RTL and testbench

- MEM-stage initiator that sits between the pipeline's load/store request and the word-wide data memory, which offers a combinational read and a posedge write.
- Converts byte, halfword and word loads and stores into word accesses.
- Sub-word stores use a read-modify-write sequence. Loads are extracted and sign- or zero-extended.
- Holds the pipeline with Stall until each access completes. Misaligned requests are flagged and never touch memory.

---
 rtl/mem_load_store_unit_pkg.sv | 32 +++
 rtl/mem_load_store_unit_if.sv | 31 +++
 rtl/mem_load_store_unit_lane_align.sv | 39 +++
 rtl/mem_load_store_unit.sv | 121 ++++++++++++
 tb/tb_mem_load_store_unit.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_load_store_unit_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes,
// controller states and the data-memory geometry.
package mips_mem_pkg;

    localparam int DMEM_ADDR_WIDTH = 9;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } lsu_state_e;

    // A request is misaligned when its low address bits do not fit its size;
    // the reserved size can never be honoured and is rejected the same way.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] byte_off);
        case (mem_size_e'(size))
            SZ_BYTE: return 1'b0;
            SZ_HALF: return byte_off[0];
            SZ_WORD: return |byte_off;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_store_unit_if.sv
// Word-wide data-memory bus: the LSU drives address/enables/write data,
// the memory returns combinational read data.
interface mem_load_store_unit_if
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH
);

    logic [ADDR_WIDTH-1:0] Mem_Addr;
    logic                  Mem_Read;
    logic                  Mem_Write;
    logic [31:0]           Mem_Wdata;
    logic [31:0]           Mem_Rdata;

    modport master (
        output Mem_Addr,
        output Mem_Read,
        output Mem_Write,
        output Mem_Wdata,
        input  Mem_Rdata
    );

    modport slave (
        input  Mem_Addr,
        input  Mem_Read,
        input  Mem_Write,
        input  Mem_Wdata,
        output Mem_Rdata
    );

endinterface

// File: rtl/mem_load_store_unit_lane_align.sv
// Little-endian lane steering between a memory word and a sub-word access:
// extracts and extends load lanes, and merges store lanes into an old word.
module lsu_lane_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  byte_off,
    input  mem_size_e   size,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Load path: pick the addressed lane and zero- or sign-extend it to 32 bits.
    always_comb begin
        byte_lane = rd_word[{byte_off, 3'b000} +: 8];
        half_lane = rd_word[{byte_off[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: load_data = is_unsigned ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            SZ_HALF: load_data = is_unsigned ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: load_data = rd_word;
        endcase
    end

    // Store path: overwrite only the addressed lane, keeping every other byte of the old word.
    always_comb begin
        merged_word = rd_word;
        case (size)
            SZ_BYTE: merged_word[{byte_off, 3'b000} +: 8]    = store_data[7:0];
            SZ_HALF: merged_word[{byte_off[1], 4'b0000} +: 16] = store_data[15:0];
            default: merged_word = store_data;
        endcase
    end

endmodule

// File: rtl/mem_load_store_unit.sv
// MEM-stage load/store unit: turns byte/half/word loads and stores into word
// accesses on a combinational-read, posedge-write memory, stalling the
// pipeline until each access completes. Sub-word stores go read-modify-write.
module mem_load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter logic [31:0] RESET_DATA = 32'd0
)(
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic                      Req_Valid_MEM,
    input  logic                      Req_Write_MEM,
    input  logic [1:0]                Req_Size_MEM,
    input  logic                      Req_Unsigned_MEM,
    input  logic [31:0]               ALU_Result_MEM,
    input  logic [31:0]               Store_Data_MEM,
    output logic                      Stall_MEM,
    output logic                      Resp_Valid_MEM,
    output logic [31:0]               Load_Data_MEM,
    output logic                      Misalign_Err_MEM,
    mem_load_store_unit_if.master     mem_bus
);

    lsu_state_e            state;
    logic [ADDR_WIDTH-1:0] addr_idx;
    logic [1:0]            byte_off;
    mem_size_e             size_q;
    logic                  unsigned_q;
    logic                  write_q;
    logic [31:0]           store_q;
    logic [31:0]           wdata_q;
    logic [31:0]           load_ext;
    logic [31:0]           merged_word;
    logic                  unused_addr_hi;

    // Address bits above the memory index wrap away by truncation.
    assign unused_addr_hi = ^ALU_Result_MEM[31:ADDR_WIDTH+2];

    lsu_lane_align u_lane_align (
        .rd_word     (mem_bus.Mem_Rdata),
        .byte_off    (byte_off),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .store_data  (store_q),
        .load_data   (load_ext),
        .merged_word (merged_word)
    );

    // Access sequencer: accept, optional read, optional write, one-cycle response.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state            <= ST_IDLE;
            Resp_Valid_MEM   <= 1'b0;
            Misalign_Err_MEM <= 1'b0;
            Load_Data_MEM    <= RESET_DATA;
        end else begin
            Resp_Valid_MEM   <= 1'b0;
            Misalign_Err_MEM <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Req_Valid_MEM) begin
                        addr_idx   <= ALU_Result_MEM[ADDR_WIDTH+1:2];
                        byte_off   <= ALU_Result_MEM[1:0];
                        size_q     <= mem_size_e'(Req_Size_MEM);
                        unsigned_q <= Req_Unsigned_MEM;
                        write_q    <= Req_Write_MEM;
                        store_q    <= Store_Data_MEM;
                        wdata_q    <= Store_Data_MEM;
                        if (is_misaligned(Req_Size_MEM, ALU_Result_MEM[1:0])) begin
                            state            <= ST_DONE;
                            Resp_Valid_MEM   <= 1'b1;
                            Misalign_Err_MEM <= 1'b1;
                            Load_Data_MEM    <= RESET_DATA;
                        end else if (Req_Write_MEM && mem_size_e'(Req_Size_MEM) == SZ_WORD) begin
                            state <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (write_q) begin
                        wdata_q <= merged_word;
                        state   <= ST_WRITE;
                    end else begin
                        Load_Data_MEM  <= load_ext;
                        Resp_Valid_MEM <= 1'b1;
                        state          <= ST_DONE;
                    end
                end
                ST_WRITE: begin
                    Load_Data_MEM  <= RESET_DATA;
                    Resp_Valid_MEM <= 1'b1;
                    state          <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pipeline hold: raised as soon as a request arrives, dropped in the response cycle.
    always_comb begin
        case (state)
            ST_IDLE:           Stall_MEM = Req_Valid_MEM;
            ST_READ, ST_WRITE: Stall_MEM = 1'b1;
            default:           Stall_MEM = 1'b0;
        endcase
    end

    // Memory strobes are gated by reset so an access caught by reset never commits.
    always_comb begin
        mem_bus.Mem_Addr  = addr_idx;
        mem_bus.Mem_Wdata = wdata_q;
        mem_bus.Mem_Read  = Rst_n && (state == ST_READ);
        mem_bus.Mem_Write = Rst_n && (state == ST_WRITE);
    end

endmodule

// File: tb/tb_mem_load_store_unit.sv
// Self-checking bench for mem_load_store_unit: directed vector table, a
// reset-during-write sequence and randomized traffic against a reference model.
module tb_mem_load_store_unit;
    import mips_mem_pkg::*;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] exp_ld;
        logic        exp_err;
        int          exp_lat;
        int          exp_reads;
        int          exp_writes;
        logic [8:0]  exp_idx;
    } vec_t;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Req_Valid_MEM;
    logic        Req_Write_MEM;
    logic [1:0]  Req_Size_MEM;
    logic        Req_Unsigned_MEM;
    logic [31:0] ALU_Result_MEM;
    logic [31:0] Store_Data_MEM;
    logic        Stall_MEM;
    logic        Resp_Valid_MEM;
    logic [31:0] Load_Data_MEM;
    logic        Misalign_Err_MEM;

    logic [31:0] dmem    [512];
    logic [31:0] ref_mem [512];
    vec_t        vecs    [12];

    int vec_count   = 0;
    int miscompares = 0;

    mem_load_store_unit_if #(.ADDR_WIDTH(9)) bus ();

    mem_load_store_unit #(
        .ADDR_WIDTH (9),
        .RESET_DATA (32'd0)
    ) dut (
        .Clk              (Clk),
        .Rst_n            (Rst_n),
        .Req_Valid_MEM    (Req_Valid_MEM),
        .Req_Write_MEM    (Req_Write_MEM),
        .Req_Size_MEM     (Req_Size_MEM),
        .Req_Unsigned_MEM (Req_Unsigned_MEM),
        .ALU_Result_MEM   (ALU_Result_MEM),
        .Store_Data_MEM   (Store_Data_MEM),
        .Stall_MEM        (Stall_MEM),
        .Resp_Valid_MEM   (Resp_Valid_MEM),
        .Load_Data_MEM    (Load_Data_MEM),
        .Misalign_Err_MEM (Misalign_Err_MEM),
        .mem_bus          (bus)
    );

    always #5 Clk = ~Clk;

    // Data memory: combinational read, commit on the rising edge.
    assign bus.Mem_Rdata = dmem[bus.Mem_Addr];
    always @(posedge Clk) begin
        if (bus.Mem_Write) dmem[bus.Mem_Addr] <= bus.Mem_Wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference model: byte-addressed arithmetic on a word array.
    task automatic model_step(input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] sd,
                              output logic [31:0] exp_ld, output logic exp_err, output int exp_lat,
                              output int exp_reads, output int exp_writes, output logic [8:0] exp_idx);
        int          idx, off, nbytes, shift;
        logic [31:0] mask, lane;
        idx        = int'((addr >> 2) % 512);
        off        = int'(addr % 4);
        exp_idx    = 9'(idx);
        exp_ld     = 32'd0;
        exp_err    = 1'b0;
        exp_reads  = 0;
        exp_writes = 0;
        exp_lat    = 1;
        if (sz == 2'b11 || (sz == 2'b01 && off % 2 != 0) || (sz == 2'b10 && off != 0)) begin
            exp_err = 1'b1;
            return;
        end
        nbytes = 1 << sz;
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        shift  = 8 * off;
        if (!wr) begin
            lane = (ref_mem[idx] >> shift) & mask;
            if (!uns && nbytes < 4 && lane[8 * nbytes - 1]) lane = lane | ~mask;
            exp_ld    = lane;
            exp_lat   = 2;
            exp_reads = 1;
        end else begin
            ref_mem[idx] = (ref_mem[idx] & ~(mask << shift)) | ((sd & mask) << shift);
            exp_lat    = (nbytes == 4) ? 2 : 3;
            exp_reads  = (nbytes == 4) ? 0 : 1;
            exp_writes = 1;
        end
    endtask

    // Issue one request and observe the bus and response until completion (bounded).
    task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] sd,
                                 output int lat, output logic [31:0] ld, output logic err,
                                 output int reads, output int writes, output int stalls,
                                 output int both, output logic [8:0] last_idx, output logic resp_after);
        lat = -1; ld = 32'hXXXX_XXXX; err = 1'bx;
        reads = 0; writes = 0; stalls = 0; both = 0; last_idx = 9'd0;
        @(negedge Clk);
        Req_Valid_MEM    = 1'b1;
        Req_Write_MEM    = wr;
        Req_Size_MEM     = sz;
        Req_Unsigned_MEM = uns;
        ALU_Result_MEM   = addr;
        Store_Data_MEM   = sd;
        #1;
        if (Stall_MEM) stalls++;
        if (bus.Mem_Read) reads++;
        if (bus.Mem_Write) writes++;
        @(posedge Clk);
        #1;
        Req_Valid_MEM    = 1'b0;
        Req_Write_MEM    = 1'($urandom);
        Req_Size_MEM     = 2'($urandom);
        Req_Unsigned_MEM = 1'($urandom);
        ALU_Result_MEM   = $urandom;
        Store_Data_MEM   = $urandom;
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clk);
            if (Stall_MEM) stalls++;
            if (bus.Mem_Read) reads++;
            if (bus.Mem_Write) writes++;
            if (bus.Mem_Read && bus.Mem_Write) both++;
            if (bus.Mem_Read || bus.Mem_Write) last_idx = bus.Mem_Addr;
            if (Resp_Valid_MEM) begin
                lat = k;
                ld  = Load_Data_MEM;
                err = Misalign_Err_MEM;
                break;
            end
        end
        @(negedge Clk);
        resp_after = Resp_Valid_MEM | Misalign_Err_MEM;
    endtask

    task automatic checkTxn(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] sd,
                            input logic [31:0] exp_ld, input logic exp_err, input int exp_lat,
                            input int exp_reads, input int exp_writes, input logic [8:0] exp_idx);
        int          lat, reads, writes, stalls, both;
        logic [31:0] ld;
        logic        err, resp_after;
        logic [8:0]  last_idx;
        applyStimulus(wr, sz, uns, addr, sd, lat, ld, err, reads, writes, stalls, both, last_idx, resp_after);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_load_data"}, ld, exp_ld);
        checkOutput({tag, "_misalign"}, {31'd0, err}, {31'd0, exp_err});
        checkOutput({tag, "_reads"}, 32'(reads), 32'(exp_reads));
        checkOutput({tag, "_writes"}, 32'(writes), 32'(exp_writes));
        checkOutput({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
        checkOutput({tag, "_rd_wr_overlap"}, 32'(both), 32'd0);
        checkOutput({tag, "_resp_one_cycle"}, {31'd0, resp_after}, 32'd0);
        checkOutput({tag, "_load_hold"}, Load_Data_MEM, exp_ld);
        if (exp_reads + exp_writes > 0)
            checkOutput({tag, "_mem_index"}, {23'd0, last_idx}, {23'd0, exp_idx});
    endtask

    initial begin
        logic [31:0] m_ld;
        logic        m_err;
        int          m_lat, m_reads, m_writes, bad_words;
        logic [8:0]  m_idx;

        Rst_n            = 1'b0;
        Req_Valid_MEM    = 1'b0;
        Req_Write_MEM    = 1'b0;
        Req_Size_MEM     = 2'b00;
        Req_Unsigned_MEM = 1'b0;
        ALU_Result_MEM   = 32'd0;
        Store_Data_MEM   = 32'd0;

        for (int i = 0; i < 512; i++) begin
            dmem[i]    <= 32'h5A5A_5A5A ^ (32'(i) * 32'h0100_0193);
            ref_mem[i]  = 32'h5A5A_5A5A ^ (32'(i) * 32'h0100_0193);
        end
        dmem[5]  <= 32'h8899_AABB; ref_mem[5]  = 32'h8899_AABB;
        dmem[3]  <= 32'h1122_3344; ref_mem[3]  = 32'h1122_3344;
        dmem[16] <= 32'hCAFE_F00D; ref_mem[16] = 32'hCAFE_F00D;

        // Reset state
        repeat (3) @(negedge Clk);
        checkOutput("reset_resp_valid", {31'd0, Resp_Valid_MEM}, 32'd0);
        checkOutput("reset_misalign", {31'd0, Misalign_Err_MEM}, 32'd0);
        checkOutput("reset_load_data", Load_Data_MEM, 32'd0);
        checkOutput("reset_stall", {31'd0, Stall_MEM}, 32'd0);
        checkOutput("reset_mem_read", {31'd0, bus.Mem_Read}, 32'd0);
        checkOutput("reset_mem_write", {31'd0, bus.Mem_Write}, 32'd0);
        Rst_n = 1'b1;
        @(negedge Clk);
        checkOutput("idle_stall_no_req", {31'd0, Stall_MEM}, 32'd0);

        // Directed vectors
        vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h16, 32'h0,         32'hFFFF_FF99, 1'b0, 2, 1, 0, 9'd5};
        vecs[1]  = '{1'b0, 2'b01, 1'b1, 32'h16, 32'h0,         32'h0000_8899, 1'b0, 2, 1, 0, 9'd5};
        vecs[2]  = '{1'b0, 2'b01, 1'b0, 32'h16, 32'h0,         32'hFFFF_8899, 1'b0, 2, 1, 0, 9'd5};
        vecs[3]  = '{1'b1, 2'b00, 1'b0, 32'h0D, 32'h0000_00EE, 32'h0,         1'b0, 3, 1, 1, 9'd3};
        vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h0C, 32'h0,         32'h1122_EE44, 1'b0, 2, 1, 0, 9'd3};
        vecs[5]  = '{1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 0, 1, 9'd8};
        vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 1, 0, 9'd8};
        vecs[7]  = '{1'b0, 2'b01, 1'b0, 32'h21, 32'h0,         32'h0,         1'b1, 1, 0, 0, 9'd8};
        vecs[8]  = '{1'b1, 2'b10, 1'b0, 32'h22, 32'h1234_5678, 32'h0,         1'b1, 1, 0, 0, 9'd8};
        vecs[9]  = '{1'b0, 2'b11, 1'b0, 32'h24, 32'h0,         32'h0,         1'b1, 1, 0, 0, 9'd9};
        vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 1, 0, 9'd8};
        vecs[11] = '{1'b0, 2'b00, 1'b1, 32'h14, 32'h0,         32'h0000_00BB, 1'b0, 2, 1, 0, 9'd5};

        foreach (vecs[i]) begin
            model_step(vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].sd,
                       m_ld, m_err, m_lat, m_reads, m_writes, m_idx);
            checkTxn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].sd,
                     vecs[i].exp_ld, vecs[i].exp_err, vecs[i].exp_lat,
                     vecs[i].exp_reads, vecs[i].exp_writes, vecs[i].exp_idx);
        end

        // Reset asserted during the write cycle of a byte store
        @(negedge Clk);
        Req_Valid_MEM  = 1'b1;
        Req_Write_MEM  = 1'b1;
        Req_Size_MEM   = 2'b00;
        ALU_Result_MEM = 32'h41;
        Store_Data_MEM = 32'h12;
        @(posedge Clk);
        #1 Req_Valid_MEM = 1'b0;
        @(negedge Clk);
        checkOutput("rstseq_read_phase", {31'd0, bus.Mem_Read}, 32'd1);
        @(negedge Clk);
        checkOutput("rstseq_write_phase", {31'd0, bus.Mem_Write}, 32'd1);
        Rst_n = 1'b0;
        #1;
        checkOutput("rstseq_write_gated", {31'd0, bus.Mem_Write}, 32'd0);
        @(negedge Clk);
        checkOutput("rstseq_resp_valid", {31'd0, Resp_Valid_MEM}, 32'd0);
        checkOutput("rstseq_misalign", {31'd0, Misalign_Err_MEM}, 32'd0);
        checkOutput("rstseq_load_data", Load_Data_MEM, 32'd0);
        checkOutput("rstseq_stall", {31'd0, Stall_MEM}, 32'd0);
        checkOutput("rstseq_mem_rw", {30'd0, bus.Mem_Read, bus.Mem_Write}, 32'd0);
        checkOutput("rstseq_mem_unchanged", dmem[16], 32'hCAFE_F00D);
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk);
        checkOutput("rstseq_no_late_resp", {30'd0, Resp_Valid_MEM, Stall_MEM}, 32'd0);
        model_step(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, m_ld, m_err, m_lat, m_reads, m_writes, m_idx);
        checkTxn("post_reset_load", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0,
                 32'hCAFE_F00D, 1'b0, 2, 1, 0, 9'd16);

        // Randomized traffic against the reference model
        for (int n = 0; n < 60; n++) begin
            logic        r_wr, r_uns;
            logic [1:0]  r_sz;
            logic [31:0] r_addr, r_sd;
            r_wr   = 1'($urandom);
            r_uns  = 1'($urandom);
            r_sz   = 2'($urandom);
            r_addr = (32'($urandom_range(0, 3)) << 11) | 32'($urandom_range(0, 127));
            r_sd   = $urandom;
            model_step(r_wr, r_sz, r_uns, r_addr, r_sd, m_ld, m_err, m_lat, m_reads, m_writes, m_idx);
            checkTxn($sformatf("rand%0d", n), r_wr, r_sz, r_uns, r_addr, r_sd,
                     m_ld, m_err, m_lat, m_reads, m_writes, m_idx);
        end

        bad_words = 0;
        for (int i = 0; i < 512; i++) begin
            if (dmem[i] !== ref_mem[i]) bad_words++;
        end
        checkOutput("final_mem_image_bad_words", 32'(bad_words), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
